// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for counters and pointer synchronisers.
// Both conversions work on GRAY_MAX_WIDTH-bit vectors. Narrower values are
// zero-extended into the low bits, and the low WIDTH bits of the result are
// the correct narrow conversion.
package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 16;

  // Binary to Gray: each Gray bit is the XOR of a binary bit and its upper neighbour.
  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] i_bin);
    return i_bin ^ (i_bin >> 1);
  endfunction

  // Gray to binary: a prefix XOR running from the MSB down.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] i_gray);
    logic [GRAY_MAX_WIDTH-1:0] v_bin;
    v_bin[GRAY_MAX_WIDTH-1] = i_gray[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      v_bin[i] = v_bin[i+1] ^ i_gray[i];
    end
    return v_bin;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Purely combinational Gray-to-binary converter of parametrised width.
// It can be reused by FIFO pointer synchronisers.
// Binary bit n is the XOR of all Gray bits from the MSB down to bit n.
module gray_to_bin
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign o_bin[gi] = ^i_gray[WIDTH-1:gi];
    end
  endgenerate

endmodule

// File: rtl/gray_counter_n.sv
// Counter behaviour:
// - Parametrised W-bit Gray-code up/down counter.
// - Provides a synchronous clear, a parallel Gray-coded load, a one-cycle
//   wrap pulse, a sticky overflow flag and a registered binary view.
//
// Optional build macro: GRAY_COUNTER_SATURATE_EN
// - When defined, stepping past either end holds the count at that end.
//   The wrap pulse and the overflow flag are still raised.
// - When undefined, the counter wraps modulo 2^WIDTH.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int INIT  = 0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             En,
  input  logic             Up,
  input  logic             Clr,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             OvfClr,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Binary,
  output logic             Wrap,
  output logic             Overflow
);

  localparam logic [WIDTH-1:0] BIN_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] BIN_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] INIT_BIN = INIT[WIDTH-1:0];
  localparam logic [GRAY_MAX_WIDTH-1:0] INIT_EXT = GRAY_MAX_WIDTH'(INIT_BIN);
  localparam logic [GRAY_MAX_WIDTH-1:0] INIT_GRAY_EXT = bin2gray(INIT_EXT);
  localparam logic [WIDTH-1:0] INIT_GRAY = INIT_GRAY_EXT[WIDTH-1:0];

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic             r_ovf;

  logic [WIDTH-1:0]          w_load_bin;
  logic [WIDTH-1:0]          w_bin_next;
  logic                      w_wrap_next;
  logic                      w_ovf_next;
  logic [GRAY_MAX_WIDTH-1:0] w_bin_ext;
  logic [GRAY_MAX_WIDTH-1:0] w_gray_ext;
  logic [WIDTH-1:0]          w_gray_next;
  logic                      w_unused_gray;

  // The load value arrives Gray-coded; the core works in binary.
  gray_to_bin #(
    .WIDTH(WIDTH)
  ) u_load_conv (
    .i_gray(LoadVal),
    .o_bin (w_load_bin)
  );

  // Next-state selection: clear, then load, then up/down step, otherwise hold.
  // OvfClr acts on every edge, but a wrap on the same edge re-sets the flag.
  always_comb begin
    w_bin_next  = r_bin;
    w_wrap_next = 1'b0;
    w_ovf_next  = r_ovf & ~OvfClr;
    if (Clr) begin
      w_bin_next = '0;
      w_ovf_next = 1'b0;
    end else if (Load) begin
      w_bin_next = w_load_bin;
    end else if (En) begin
      if (Up) begin
        if (r_bin == BIN_MAX) begin
          w_wrap_next = 1'b1;
          w_ovf_next  = 1'b1;
`ifdef GRAY_COUNTER_SATURATE_EN
          w_bin_next  = BIN_MAX;
`else
          w_bin_next  = '0;
`endif
        end else begin
          w_bin_next = r_bin + BIN_ONE;
        end
      end else begin
        if (r_bin == '0) begin
          w_wrap_next = 1'b1;
          w_ovf_next  = 1'b1;
`ifdef GRAY_COUNTER_SATURATE_EN
          w_bin_next  = '0;
`else
          w_bin_next  = BIN_MAX;
`endif
        end else begin
          w_bin_next = r_bin - BIN_ONE;
        end
      end
    end
  end

  // Widen the next binary value so the shared package encoder can be used.
  always_comb begin
    w_bin_ext = '0;
    w_bin_ext[WIDTH-1:0] = w_bin_next;
  end

  assign w_gray_ext    = bin2gray(w_bin_ext);
  assign w_gray_next   = w_gray_ext[WIDTH-1:0];
  assign w_unused_gray = ^w_gray_ext;

  // State register.
  // The Gray and binary outputs are both registered, so no input reaches
  // an output combinationally.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_bin  <= INIT_BIN;
      r_gray <= INIT_GRAY;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
      r_wrap <= w_wrap_next;
      r_ovf  <= w_ovf_next;
    end
  end

  assign Output   = r_gray;
  assign Binary   = r_bin;
  assign Wrap     = r_wrap;
  assign Overflow = r_ovf;

endmodule

// File: tb/tb_gray_counter_n.sv
// Scoreboard bench for gray_counter_n.
// - Stimulus pushes hand-computed expectations into a queue.
// - A monitor pops one entry 1 time unit after each rising clock edge, or
//   after an explicit mid-cycle check event, and compares it with the DUT.
// - Counting steps also check that exactly one Gray bit flipped.
// Honours GRAY_COUNTER_SATURATE_EN for the expected end-of-range values.
module tb_gray_counter_n;

`ifdef GRAY_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // 3-bit end-of-range results: modulo wrap, or hold in saturate builds.
  localparam logic [2:0] UPW_G3 = SAT ? 3'b100 : 3'b000;
  localparam logic [2:0] UPW_B3 = SAT ? 3'b111 : 3'b000;
  localparam logic [2:0] DNW_G3 = SAT ? 3'b000 : 3'b100;
  localparam logic [2:0] DNW_B3 = SAT ? 3'b000 : 3'b111;
  localparam logic [3:0] DNW_G4 = SAT ? 4'b0000 : 4'b1000;
  localparam logic [3:0] DNW_B4 = SAT ? 4'b0000 : 4'b1111;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       rst3_n = 1'b0, en3 = 1'b0, up3 = 1'b0, clr3 = 1'b0, load3 = 1'b0, oc3 = 1'b0;
  logic [2:0] lv3 = '0;
  logic [2:0] g3, b3;
  logic       w3, o3;

  logic       rst4_n = 1'b0, en4 = 1'b0, up4 = 1'b0, clr4 = 1'b0, load4 = 1'b0, oc4 = 1'b0;
  logic [3:0] lv4 = '0;
  logic [3:0] g4, b4;
  logic       w4, o4;

  gray_counter_n #(.WIDTH(3), .INIT(0)) u_dut3 (
    .Clk(Clk), .Reset_n(rst3_n), .En(en3), .Up(up3), .Clr(clr3), .Load(load3),
    .LoadVal(lv3), .OvfClr(oc3), .Output(g3), .Binary(b3), .Wrap(w3), .Overflow(o3)
  );

  gray_counter_n #(.WIDTH(4), .INIT(0)) u_dut4 (
    .Clk(Clk), .Reset_n(rst4_n), .En(en4), .Up(up4), .Clr(clr4), .Load(load4),
    .LoadVal(lv4), .OvfClr(oc4), .Output(g4), .Binary(b4), .Wrap(w4), .Overflow(o4)
  );

  typedef struct packed {
    logic       sel4;
    logic [3:0] g;
    logic [3:0] b;
    logic       w;
    logic       o;
    logic       c1;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;
  event  chk_ev;

  task automatic push(input logic s4, input logic [3:0] g, input logic [3:0] b,
                      input logic w, input logic o, input logic c1, input string nm);
    exp_t e;
    e.sel4 = s4; e.g = g; e.b = b; e.w = w; e.o = o; e.c1 = c1;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Expectation observed at the next monitor trigger, without waiting for a clock.
  task automatic check_now(input logic s4, input logic [3:0] g, input logic [3:0] b,
                           input logic w, input logic o, input string nm);
    push(s4, g, b, w, o, 1'b0, nm);
    ->chk_ev;
    #2;
  endtask

  task automatic step3(input logic en, input logic up, input logic clr, input logic load,
                       input logic [2:0] lv, input logic oc,
                       input logic [2:0] eg, input logic [2:0] eb,
                       input logic ew, input logic eo, input logic c1, input string nm);
    @(negedge Clk);
    en3 = en; up3 = up; clr3 = clr; load3 = load; lv3 = lv; oc3 = oc;
    push(1'b0, {1'b0, eg}, {1'b0, eb}, ew, eo, c1, nm);
  endtask

  task automatic step4(input logic rst_n, input logic en, input logic up, input logic load,
                       input logic [3:0] lv,
                       input logic [3:0] eg, input logic [3:0] eb,
                       input logic ew, input logic eo, input logic c1, input string nm);
    @(negedge Clk);
    rst4_n = rst_n; en4 = en; up4 = up; load4 = load; lv4 = lv;
    push(1'b1, eg, eb, ew, eo, c1, nm);
  endtask

  // Monitor: compares one queued expectation per trigger.
  initial begin
    exp_t       e;
    string      nm;
    logic [3:0] ag, ab, pg;
    logic       aw, ao;
    logic [3:0] prev3, prev4;
    prev3 = '0;
    prev4 = '0;
    forever begin
      @(posedge Clk or chk_ev);
      #1;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.sel4) begin
          ag = g4; ab = b4; aw = w4; ao = o4; pg = prev4;
        end else begin
          ag = {1'b0, g3}; ab = {1'b0, b3}; aw = w3; ao = o3; pg = prev3;
        end
        total++;
        if ({ag, ab, aw, ao} !== {e.g, e.b, e.w, e.o}) begin
          bad++;
          $display("FAIL %s: got gray=%b bin=%b wrap=%b ovf=%b, want gray=%b bin=%b wrap=%b ovf=%b",
                   nm, ag, ab, aw, ao, e.g, e.b, e.w, e.o);
        end else begin
          $display("ok   %s: gray=%b bin=%b wrap=%b ovf=%b", nm, ag, ab, aw, ao);
        end
        if (e.c1) begin
          total++;
          if ($countones(ag ^ pg) != 1) begin
            bad++;
            $display("FAIL %s onebit: prev=%b now=%b, want exactly one flipped bit", nm, pg, ag);
          end
        end
        if (e.sel4) prev4 = ag;
        else        prev3 = ag;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end by time limit, want finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus with hand-computed expectations.
  initial begin
    // While reset is held, both counters show the INIT encoding with flags low.
    #1;
    check_now(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, "reset3");
    check_now(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, "reset4");
    @(negedge Clk);
    rst3_n = 1'b1;
    rst4_n = 1'b1;

    // 3-bit up sweep through the wrap.
    step3(0,0,0,0,3'b000,0, 3'b000,3'b000,0,0,0, "hold0");
    step3(1,1,0,0,3'b000,0, 3'b001,3'b001,0,0,1, "up1");
    step3(1,1,0,0,3'b000,0, 3'b011,3'b010,0,0,1, "up2");
    step3(1,1,0,0,3'b000,0, 3'b010,3'b011,0,0,1, "up3");
    step3(1,1,0,0,3'b000,0, 3'b110,3'b100,0,0,1, "up4");
    step3(1,1,0,0,3'b000,0, 3'b111,3'b101,0,0,1, "up5");
    step3(1,1,0,0,3'b000,0, 3'b101,3'b110,0,0,1, "up6");
    step3(1,1,0,0,3'b000,0, 3'b100,3'b111,0,0,1, "up7");
    step3(1,1,0,0,3'b000,0, UPW_G3,UPW_B3,1,1,!SAT, "upwrap");
    step3(0,0,0,0,3'b000,0, UPW_G3,UPW_B3,0,1,0, "hold_after_wrap");

    // Clear, down-wrap, then clear the sticky flag on its own.
    step3(0,0,1,0,3'b000,0, 3'b000,3'b000,0,0,0, "clr");
    step3(1,0,0,0,3'b000,0, DNW_G3,DNW_B3,1,1,!SAT, "downwrap");
    step3(0,0,0,0,3'b000,1, DNW_G3,DNW_B3,0,0,0, "ovfclr");

    // Parallel load and the priority of load over counting.
    step3(0,0,0,1,3'b110,0, 3'b110,3'b100,0,0,0, "load110");
    step3(1,1,0,0,3'b000,0, 3'b111,3'b101,0,0,1, "up_after_load");
    step3(1,1,0,1,3'b011,0, 3'b011,3'b010,0,0,0, "load_beats_en");

    // A wrap beats OvfClr on the same edge; a load leaves the flag alone.
    step3(0,0,0,1,3'b100,0, 3'b100,3'b111,0,0,0, "load100");
    step3(1,1,0,0,3'b000,1, UPW_G3,UPW_B3,1,1,!SAT, "wrap_beats_ovfclr");
    step3(0,0,0,1,3'b010,0, 3'b010,3'b011,0,1,0, "load_keeps_ovf");
    step3(1,0,0,0,3'b000,0, 3'b011,3'b010,0,1,1, "down1");
    step3(1,0,0,0,3'b000,0, 3'b001,3'b001,0,1,1, "down2");
    step3(1,0,0,0,3'b000,0, 3'b000,3'b000,0,1,1, "down3");
    step3(1,1,1,1,3'b101,0, 3'b000,3'b000,0,0,0, "clr_beats_load");
    step3(0,0,0,0,3'b000,0, 3'b000,3'b000,0,0,0, "hold_end3");

    // 4-bit counter: raise the overflow flag, then count to Gray 0110.
    step4(1,0,0,0,4'b0000, 4'b0000,4'b0000,0,0,0, "d4_hold");
    step4(1,1,0,0,4'b0000, DNW_G4,DNW_B4,1,1,!SAT, "d4_downwrap");
    step4(1,0,0,1,4'b0000, 4'b0000,4'b0000,0,1,0, "d4_load0");
    step4(1,1,1,0,4'b0000, 4'b0001,4'b0001,0,1,1, "d4_up1");
    step4(1,1,1,0,4'b0000, 4'b0011,4'b0010,0,1,1, "d4_up2");
    step4(1,1,1,0,4'b0000, 4'b0010,4'b0011,0,1,1, "d4_up3");
    step4(1,1,1,0,4'b0000, 4'b0110,4'b0100,0,1,1, "d4_up4");

    // Drop reset between edges: outputs clear at once, edges are ignored meanwhile.
    @(posedge Clk);
    #2;
    rst4_n = 1'b0;
    check_now(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, "d4_async_reset");
    step4(0,1,1,0,4'b0000, 4'b0000,4'b0000,0,0,0, "d4_held_in_reset");
    step4(1,1,1,0,4'b0000, 4'b0001,4'b0001,0,0,1, "d4_after_release");
    step4(1,0,0,0,4'b0000, 4'b0001,4'b0001,0,0,0, "d4_hold_end");

    repeat (3) @(negedge Clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_counter_n.md
Name: gray_counter_n

Overview:
- Parametrised W-bit Gray-code counter. Successor to the fixed 3-bit up-only Gray counter.
- Adds up/down counting, a synchronous clear, a parallel load, a one-cycle wrap pulse, a sticky overflow flag with its own clear, and a binary-equivalent output.
- Used as a pointer/sequence source in CPU-side timing and FIFO-pointer logic, where only one bit may change per step.

Parameters:
- WIDTH, 3, counter width in bits; legal range 2..16.
- INIT, 0, binary value loaded on reset; Output resets to the Gray encoding of INIT.

Ports:
- Clk  input  1  rising-edge clock
- Reset_n  input  1  asynchronous active-low reset; assertion takes effect immediately, deassertion is synchronised externally
- En  input  1  count enable; one step per Clk edge while high
- Up  input  1  direction select: 1 = increment, 0 = decrement
- Clr  input  1  synchronous clear to Gray 0
- Load  input  1  synchronous parallel load
- LoadVal  input  WIDTH  Gray-coded load value; every WIDTH-bit pattern is valid
- OvfClr  input  1  synchronous clear of Overflow
- Output  output  WIDTH  registered Gray count
- Binary  output  WIDTH  registered binary equivalent of Output
- Wrap  output  1  one-cycle pulse, coincident with the wrapped value
- Overflow  output  1  sticky wrap flag

Behaviour:
- State:
  - Internal binary register B (WIDTH bits).
  - Output is B ^ (B >> 1). Binary equals B.
  - Both outputs are registered; there is no combinational path from inputs to outputs.
- Reset (Reset_n = 0, asynchronous):
  - B = INIT, Output = gray(INIT), Binary = INIT.
  - Wrap = 0, Overflow = 0.
  - Reset mid-count discards the in-flight step.
- Per-edge priority, highest first:
  1. Clr: B = 0, Wrap = 0, Overflow = 0.
  2. Load: B = gray2bin(LoadVal), Wrap = 0, Overflow unchanged.
  3. En with Up = 1: B = B + 1 modulo 2^WIDTH.
  4. En with Up = 0: B = B - 1 modulo 2^WIDTH.
  5. Otherwise: hold; Wrap = 0.
- Up-wrap: when B = 2^WIDTH - 1 (Gray 100..0) and an up step occurs:
  - B becomes 0.
  - Wrap = 1 for that cycle.
  - Overflow set.
- Down-wrap: when B = 0 and a down step occurs:
  - B becomes 2^WIDTH - 1.
  - Wrap = 1 for that cycle.
  - Overflow set.
- Overflow:
  - Cleared only by Reset_n, Clr, or OvfClr.
  - If OvfClr and a wrap fall on the same edge, set wins and Overflow = 1.
- Gray sequence:
  - Consecutive Output values always differ in exactly one bit, including across a wrap.
  - Load and Clr are exempt from this one-bit rule.
- Sequence check for WIDTH = 3, counting up: 000, 001, 011, 010, 110, 111, 101, 100, 000.
- Arithmetic:
  - Modulo WIDTH bits; there is no carry-out port.
  - gray2bin is a prefix XOR from the MSB down.

Optional Feature:
- Macro: GRAY_COUNTER_SATURATE_EN.
- Defined:
  - An up step at B = max holds B at max.
  - A down step at B = 0 holds B at 0.
  - In both cases Overflow is set and Wrap pulses.
- Undefined: modulo wrap as described under Behaviour.

Decomposition:
- Package gray_pkg holds:
  - Function bin2gray(WIDTH).
  - Function gray2bin(WIDTH).
  - Constant GRAY_MAX_WIDTH = 16.
- One combinational sub-module, gray_to_bin (parametrised WIDTH), converts LoadVal. It is reusable by FIFO pointer synchronisers.
- The counter core stays in gray_counter_n.

Test Plan:
- Up-wrap: WIDTH = 3, reset, then En = 1 and Up = 1 for 8 cycles. Output must step 001, 011, 010, 110, 111, 101, 100, 000. Wrap = 1 only on the 000 cycle. Overflow = 1 from that cycle onward.
- Down-wrap: WIDTH = 3, reset, then En = 1 and Up = 0 for 1 cycle. Output = 100, Binary = 111, Wrap = 1, Overflow = 1. Pulse OvfClr: Overflow = 0.
- Load: WIDTH = 3, Load = 1 with LoadVal = 110. Output = 110, Binary = 100. Then one up step gives Output = 111, Binary = 101. Load and En together: Load wins.
- Async reset: WIDTH = 4 with count at 0110. Drop Reset_n between Clk edges. Output = 0000 and Overflow = 0 before the next edge; Clk edges are ignored while Reset_n = 0.
- Simultaneous events: OvfClr = 1 on the edge where the count goes 100 to 000. Overflow stays 1. Clr and Load together: Output = 000.
- Saturate build (GRAY_COUNTER_SATURATE_EN defined), WIDTH = 3 at 100: an up step leaves Output = 100 and sets Overflow = 1. Every bench run also checks that each non-load, non-clear step flips exactly one bit.
